punc_ctrl_fsm: RTL and testbench
================================

// Module: punc_ctrl_fsm
// PURPOSE
// - Control unit for the PUnC LC3 datapath; sequences fetch/decode/execute for one instruction at a time.
// - Drives every datapath select/load/enable from the IR opcode and the registered n/z/p flags.
// - Sits beside the datapath in the PUnC top level; memory reads are asynchronous and writes are clocked.
// PARAMETERS
// - HALT_TRAPVECT  8'h25  TRAP vector that halts; any other TRAP executes as NOP.
// - CC_ON_LEA      0      1 = LEA updates n/z/p; 0 = LEA leaves flags untouched.
// PORTS
// - clk          in   1   clock; all state changes on rising edge
// - rst          in   1   synchronous, active-low reset
// - ir           in   16  current instruction register from datapath
// - n, z, p      in   1   registered condition codes from datapath
// - pc_clr       out  1   clear PC to 0
// - pc_inc       out  1   PC <= PC+1
// - pc_ld        out  1   load PC from pc_data_sel source
// - pc_data_sel  out  1   0 = PC+sext(offset), 1 = ALU result
// - pc_add_sel   out  1   0 = offset11, 1 = offset9
// - ir_ld        out  1   IR <= mem[addr]
// - mem_addr_sel out  2   0 = PC, 1 = ALU result, 2 = indirect-address register
// - mem_w_en     out  1   memory write strobe (data = RF read port 1)
// - ind_ld       out  1   indirect-address register <= memory read data
// - rf_r_addr_0  out  3   RF read port 0 address (SR1/BaseR)
// - rf_r_addr_1  out  3   RF read port 1 address (SR2/SR for stores)
// - rf_w_addr    out  3   RF write address
// - rf_w_en      out  1   RF write enable
// - rf_w_sel     out  2   0 = PC, 1 = memory data, 2 = ALU result
// - a_sel        out  1   ALU A: 0 = PC, 1 = RF port 0
// - b_sel        out  1   ALU B: 0 = RF port 1, 1 = sext_data
// - sext_data    out  16  sign-extended imm5/offset6/offset9 chosen by opcode
// - alu_sel      out  2   0 = ADD, 1 = AND, 2 = PASS_A, 3 = NOT
// - nzp_sel      out  1   flag source: 0 = ALU result, 1 = memory data
// - nzp_ld       out  1   update n/z/p from the nzp_sel source
// - halted       out  1   high while in S_HALT
// BEHAVIOUR
// - States: S_INIT, S_FETCH, S_DECODE, S_EXEC, S_EXEC2, S_HALT.
// - Outputs are decoded from state and ir; every output is 0 unless asserted for that state.
// - Reset: rst==0 at a clock edge forces S_INIT from any state, including mid-instruction; an in-flight store is
//   abandoned and no mem_w_en/rf_w_en is issued in the cycle after reset. While rst==0, all outputs are 0.
// - S_INIT: pc_clr=1 -> S_FETCH.
// - S_FETCH: mem_addr_sel=0, ir_ld=1 -> S_DECODE.
// - S_DECODE: pc_inc=1. Go to S_HALT if opcode==4'b1111 and ir[7:0]==HALT_TRAPVECT; otherwise go to S_EXEC.
// - S_EXEC, one cycle; all opcodes return to S_FETCH except LDI/STI, which go to S_EXEC2.
//   - ADD/AND: a_sel=1; b_sel=ir[5]; alu_sel=ADD or AND; rf_w_sel=2; rf_w_en=1; nzp_ld=1.
//   - NOT: a_sel=1; alu_sel=NOT; rf_w_sel=2; rf_w_en=1; nzp_ld=1.
//   - BR: taken = (ir[11]&n) | (ir[10]&z) | (ir[9]&p). If taken: pc_ld=1, pc_data_sel=0, pc_add_sel=1.
//     With nzp field 000 the branch is never taken.
//   - JMP/RET: a_sel=1; alu_sel=PASS_A; pc_ld=1; pc_data_sel=1.
//   - JSR/JSRR: rf_w_addr=7, rf_w_sel=0, rf_w_en=1. PC is loaded on the same edge (JSR: offset11; JSRR: BaseR via ALU).
//     JSRR R7 jumps to the old R7, because the read is combinational and the write lands at the edge.
//   - LD: a_sel=0, b_sel=1 (off9), ADD, mem_addr_sel=1, rf_w_sel=1, rf_w_en=1, nzp_sel=1, nzp_ld=1.
//   - LDR: as LD, but a_sel=1 and the offset is off6.
//   - LEA: PC+off9 via ALU; rf_w_sel=2; rf_w_en=1; nzp_ld=CC_ON_LEA.
//   - ST/STR: address via ALU as LD/LDR; mem_addr_sel=1; rf_r_addr_1=ir[11:9]; mem_w_en=1.
//   - LDI/STI: PC+off9 via ALU; mem_addr_sel=1; ind_ld=1.
//   - Reserved/RTI (1000, 1101) and non-halt TRAP: no strobes (NOP).
// - S_EXEC2: mem_addr_sel=2. LDI: rf_w_sel=1, rf_w_en=1, nzp_sel=1, nzp_ld=1. STI: mem_w_en=1. Then -> S_FETCH.
// - Flags: nzp_ld and rf_w_en for the same instruction occur in the same cycle.
// - Latency: 3 cycles per instruction (FETCH, DECODE, EXEC); LDI/STI take 4 cycles. PC wraps 16'hFFFF -> 0.
// - S_HALT: absorbing; halted=1; all strobes 0 until rst==0.
// STRUCTURE
// - Shared package punc_ctrl_pkg: state encodings, opcode constants, and all select-code constants
//   (mem_addr_sel, rf_w_sel, alu_sel, a/b/pc/nzp sels); the datapath uses the same constants.
// - Sub-module punc_ctrl_decode: combinational {state, ir, n, z, p} -> control vector.
//   The top level holds only the state register and next-state logic.
// TESTING
// - Reset: rst=0 for 2 cycles, then 1 -> cycle 1: pc_clr=1; cycle 2: ir_ld=1 with mem_addr_sel=0; no writes.
// - ADD R1,R2,#-3 (16'h12BD) -> 3rd cycle: b_sel=1, sext_data=16'hFFFD, rf_w_addr=1, rf_w_en=1, nzp_ld=1.
// - BRz #5 (16'h0405): with z=1 -> pc_ld=1, pc_add_sel=1; with z=0 -> pc_ld=0. BR with nzp=000 -> pc_ld=0.
// - JSRR R7 (16'h41C0) -> one EXEC cycle with rf_w_en=1, rf_w_addr=7, rf_w_sel=0, pc_ld=1, pc_data_sel=1.
// - LDI R3,#2 (16'hA602) -> 4 cycles: EXEC ind_ld=1; EXEC2 mem_addr_sel=2, rf_w_en=1, nzp_sel=1.
//   Reset asserted during EXEC2 -> rf_w_en=0 and the next state is S_INIT.
// - TRAP x25 (16'hF025) -> halted=1 from the cycle after DECODE onward; no strobes for 10 cycles.
//   TRAP x20 -> NOP, then fetch resumes.

Source files
------------

// File: rtl/punc_ctrl_pkg.sv
// Shared encodings for the PUnC LC3 control unit and datapath: FSM states,
// opcodes, select codes and the packed control vector.
package punc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_EXEC2  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [1:0] MEM_ADDR_PC  = 2'd0;
  localparam logic [1:0] MEM_ADDR_ALU = 2'd1;
  localparam logic [1:0] MEM_ADDR_IND = 2'd2;

  localparam logic [1:0] RF_W_PC  = 2'd0;
  localparam logic [1:0] RF_W_MEM = 2'd1;
  localparam logic [1:0] RF_W_ALU = 2'd2;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_AND    = 2'd1;
  localparam logic [1:0] ALU_PASS_A = 2'd2;
  localparam logic [1:0] ALU_NOT    = 2'd3;

  localparam logic A_PC         = 1'b0;
  localparam logic A_RF         = 1'b1;
  localparam logic B_RF         = 1'b0;
  localparam logic B_SEXT       = 1'b1;
  localparam logic PC_DATA_ADD  = 1'b0;
  localparam logic PC_DATA_ALU  = 1'b1;
  localparam logic PC_ADD_OFF11 = 1'b0;
  localparam logic PC_ADD_OFF9  = 1'b1;
  localparam logic NZP_ALU      = 1'b0;
  localparam logic NZP_MEM      = 1'b1;

  localparam logic [2:0] LINK_REG = 3'd7;

  typedef struct packed {
    logic        pc_clr;
    logic        pc_inc;
    logic        pc_ld;
    logic        pc_data_sel;
    logic        pc_add_sel;
    logic        ir_ld;
    logic [1:0]  mem_addr_sel;
    logic        mem_w_en;
    logic        ind_ld;
    logic [2:0]  rf_r_addr_0;
    logic [2:0]  rf_r_addr_1;
    logic [2:0]  rf_w_addr;
    logic        rf_w_en;
    logic [1:0]  rf_w_sel;
    logic        a_sel;
    logic        b_sel;
    logic [15:0] sext_data;
    logic [1:0]  alu_sel;
    logic        nzp_sel;
    logic        nzp_ld;
    logic        halted;
  } ctrl_t;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[15:12];
  endfunction

  function automatic logic is_halt(input logic [15:0] instr, input logic [7:0] vect);
    return (instr[15:12] == OP_TRAP) && (instr[7:0] == vect);
  endfunction

endpackage

// File: rtl/punc_ctrl_decode.sv
// Combinational control decode: maps {state, ir, n, z, p} to the full datapath
// control vector. Everything not asserted for a state/opcode stays 0.
module punc_ctrl_decode
  import punc_ctrl_pkg::*;
#(
  parameter logic CC_ON_LEA = 1'b0
) (
  input  state_t      state,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  output ctrl_t       ctrl
);

  logic [3:0]  op;
  logic [15:0] imm5;
  logic [15:0] off6;
  logic [15:0] off9;
  logic        br_taken;

  assign op       = opcode_of(ir);
  assign imm5     = {{11{ir[4]}}, ir[4:0]};
  assign off6     = {{10{ir[5]}}, ir[5:0]};
  assign off9     = {{7{ir[8]}}, ir[8:0]};
  assign br_taken = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);

  always_comb begin
    // NOTE: default the whole vector first so no path through the case leaves
    // a field unassigned; otherwise synthesis infers latches.
    ctrl = '0;
    case (state)
      S_INIT:   ctrl.pc_clr = 1'b1;
      S_FETCH: begin
        ctrl.mem_addr_sel = MEM_ADDR_PC;
        ctrl.ir_ld        = 1'b1;
      end
      S_DECODE: ctrl.pc_inc = 1'b1;
      S_EXEC: begin
        case (op)
          OP_ADD, OP_AND: begin
            ctrl.a_sel       = A_RF;
            ctrl.b_sel       = ir[5];
            ctrl.alu_sel     = (op == OP_ADD) ? ALU_ADD : ALU_AND;
            ctrl.rf_r_addr_0 = ir[8:6];
            ctrl.rf_r_addr_1 = ir[5] ? 3'd0 : ir[2:0];
            ctrl.sext_data   = ir[5] ? imm5 : 16'h0000;
            ctrl.rf_w_addr   = ir[11:9];
            ctrl.rf_w_sel    = RF_W_ALU;
            ctrl.rf_w_en     = 1'b1;
            ctrl.nzp_sel     = NZP_ALU;
            ctrl.nzp_ld      = 1'b1;
          end
          OP_NOT: begin
            ctrl.a_sel       = A_RF;
            ctrl.alu_sel     = ALU_NOT;
            ctrl.rf_r_addr_0 = ir[8:6];
            ctrl.rf_w_addr   = ir[11:9];
            ctrl.rf_w_sel    = RF_W_ALU;
            ctrl.rf_w_en     = 1'b1;
            ctrl.nzp_ld      = 1'b1;
          end
          OP_BR: begin
            if (br_taken) begin
              ctrl.pc_ld       = 1'b1;
              ctrl.pc_data_sel = PC_DATA_ADD;
              ctrl.pc_add_sel  = PC_ADD_OFF9;
            end
          end
          OP_JMP: begin
            ctrl.a_sel       = A_RF;
            ctrl.alu_sel     = ALU_PASS_A;
            ctrl.rf_r_addr_0 = ir[8:6];
            ctrl.pc_ld       = 1'b1;
            ctrl.pc_data_sel = PC_DATA_ALU;
          end
          OP_JSR: begin
            // Link write and PC load share one edge, so JSRR R7 reads the old R7.
            ctrl.rf_w_addr = LINK_REG;
            ctrl.rf_w_sel  = RF_W_PC;
            ctrl.rf_w_en   = 1'b1;
            ctrl.pc_ld     = 1'b1;
            if (ir[11]) begin
              ctrl.pc_data_sel = PC_DATA_ADD;
              ctrl.pc_add_sel  = PC_ADD_OFF11;
            end else begin
              ctrl.a_sel       = A_RF;
              ctrl.alu_sel     = ALU_PASS_A;
              ctrl.rf_r_addr_0 = ir[8:6];
              ctrl.pc_data_sel = PC_DATA_ALU;
            end
          end
          OP_LD, OP_LDR: begin
            ctrl.a_sel        = (op == OP_LDR) ? A_RF : A_PC;
            ctrl.b_sel        = B_SEXT;
            ctrl.alu_sel      = ALU_ADD;
            ctrl.rf_r_addr_0  = (op == OP_LDR) ? ir[8:6] : 3'd0;
            ctrl.sext_data    = (op == OP_LDR) ? off6 : off9;
            ctrl.mem_addr_sel = MEM_ADDR_ALU;
            ctrl.rf_w_addr    = ir[11:9];
            ctrl.rf_w_sel     = RF_W_MEM;
            ctrl.rf_w_en      = 1'b1;
            ctrl.nzp_sel      = NZP_MEM;
            ctrl.nzp_ld       = 1'b1;
          end
          OP_ST, OP_STR: begin
            ctrl.a_sel        = (op == OP_STR) ? A_RF : A_PC;
            ctrl.b_sel        = B_SEXT;
            ctrl.alu_sel      = ALU_ADD;
            ctrl.rf_r_addr_0  = (op == OP_STR) ? ir[8:6] : 3'd0;
            ctrl.sext_data    = (op == OP_STR) ? off6 : off9;
            ctrl.mem_addr_sel = MEM_ADDR_ALU;
            ctrl.rf_r_addr_1  = ir[11:9];
            ctrl.mem_w_en     = 1'b1;
          end
          OP_LEA: begin
            ctrl.a_sel     = A_PC;
            ctrl.b_sel     = B_SEXT;
            ctrl.alu_sel   = ALU_ADD;
            ctrl.sext_data = off9;
            ctrl.rf_w_addr = ir[11:9];
            ctrl.rf_w_sel  = RF_W_ALU;
            ctrl.rf_w_en   = 1'b1;
            ctrl.nzp_sel   = NZP_ALU;
            ctrl.nzp_ld    = CC_ON_LEA;
          end
          OP_LDI, OP_STI: begin
            ctrl.a_sel        = A_PC;
            ctrl.b_sel        = B_SEXT;
            ctrl.alu_sel      = ALU_ADD;
            ctrl.sext_data    = off9;
            ctrl.mem_addr_sel = MEM_ADDR_ALU;
            ctrl.ind_ld       = 1'b1;
          end
          default: ;  // RTI, reserved and non-halting TRAP execute as NOP
        endcase
      end
      S_EXEC2: begin
        ctrl.mem_addr_sel = MEM_ADDR_IND;
        if (op == OP_LDI) begin
          ctrl.rf_w_addr = ir[11:9];
          ctrl.rf_w_sel  = RF_W_MEM;
          ctrl.rf_w_en   = 1'b1;
          ctrl.nzp_sel   = NZP_MEM;
          ctrl.nzp_ld    = 1'b1;
        end else begin
          ctrl.rf_r_addr_1 = ir[11:9];
          ctrl.mem_w_en    = 1'b1;
        end
      end
      S_HALT:  ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/punc_ctrl_fsm.sv
// PUnC LC3 control FSM: state register and next-state logic; the control
// vector comes from punc_ctrl_decode and is forced to 0 while rst is low.
module punc_ctrl_fsm
  import punc_ctrl_pkg::*;
#(
  parameter logic [7:0] HALT_TRAPVECT = 8'h25,
  parameter logic       CC_ON_LEA     = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  output logic        pc_clr,
  output logic        pc_inc,
  output logic        pc_ld,
  output logic        pc_data_sel,
  output logic        pc_add_sel,
  output logic        ir_ld,
  output logic [1:0]  mem_addr_sel,
  output logic        mem_w_en,
  output logic        ind_ld,
  output logic [2:0]  rf_r_addr_0,
  output logic [2:0]  rf_r_addr_1,
  output logic [2:0]  rf_w_addr,
  output logic        rf_w_en,
  output logic [1:0]  rf_w_sel,
  output logic        a_sel,
  output logic        b_sel,
  output logic [15:0] sext_data,
  output logic [1:0]  alu_sel,
  output logic        nzp_sel,
  output logic        nzp_ld,
  output logic        halted
);

  state_t state;
  ctrl_t  dec_ctrl;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values; blocking here would create ordering races.
    if (!rst) begin
      state <= S_INIT;
    end else begin
      case (state)
        S_INIT:   state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: state <= is_halt(ir, HALT_TRAPVECT) ? S_HALT : S_EXEC;
        S_EXEC:   state <= (opcode_of(ir) == OP_LDI || opcode_of(ir) == OP_STI) ? S_EXEC2 : S_FETCH;
        S_EXEC2:  state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_INIT;
      endcase
    end
  end

  punc_ctrl_decode #(
    .CC_ON_LEA(CC_ON_LEA)
  ) u_decode (
    .state(state),
    .ir   (ir),
    .n    (n),
    .z    (z),
    .p    (p),
    .ctrl (dec_ctrl)
  );

  // Gating with rst drops any in-flight write strobe in the very cycle reset is asserted.
  assign ctrl = rst ? dec_ctrl : '0;

  assign pc_clr       = ctrl.pc_clr;
  assign pc_inc       = ctrl.pc_inc;
  assign pc_ld        = ctrl.pc_ld;
  assign pc_data_sel  = ctrl.pc_data_sel;
  assign pc_add_sel   = ctrl.pc_add_sel;
  assign ir_ld        = ctrl.ir_ld;
  assign mem_addr_sel = ctrl.mem_addr_sel;
  assign mem_w_en     = ctrl.mem_w_en;
  assign ind_ld       = ctrl.ind_ld;
  assign rf_r_addr_0  = ctrl.rf_r_addr_0;
  assign rf_r_addr_1  = ctrl.rf_r_addr_1;
  assign rf_w_addr    = ctrl.rf_w_addr;
  assign rf_w_en      = ctrl.rf_w_en;
  assign rf_w_sel     = ctrl.rf_w_sel;
  assign a_sel        = ctrl.a_sel;
  assign b_sel        = ctrl.b_sel;
  assign sext_data    = ctrl.sext_data;
  assign alu_sel      = ctrl.alu_sel;
  assign nzp_sel      = ctrl.nzp_sel;
  assign nzp_ld       = ctrl.nzp_ld;
  assign halted       = ctrl.halted;

endmodule

// File: tb/tb_punc_ctrl_fsm.sv
// Scoreboard bench for punc_ctrl_fsm: each scenario queues per-cycle stimulus
// with the expected control vector, then drains the queue cycle by cycle.
module tb_punc_ctrl_fsm;

  typedef struct packed {
    logic        pc_clr;
    logic        pc_inc;
    logic        pc_ld;
    logic        pc_data_sel;
    logic        pc_add_sel;
    logic        ir_ld;
    logic [1:0]  mem_addr_sel;
    logic        mem_w_en;
    logic        ind_ld;
    logic [2:0]  rf_r_addr_0;
    logic [2:0]  rf_r_addr_1;
    logic [2:0]  rf_w_addr;
    logic        rf_w_en;
    logic [1:0]  rf_w_sel;
    logic        a_sel;
    logic        b_sel;
    logic [15:0] sext_data;
    logic [1:0]  alu_sel;
    logic        nzp_sel;
    logic        nzp_ld;
    logic        halted;
  } obs_t;

  typedef struct {
    string       name;
    logic        rst;
    logic [15:0] ir;
    logic [2:0]  nzp;
    obs_t        exp;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] ir  = 16'h0000;
  logic        n = 1'b0, z = 1'b0, p = 1'b0;
  obs_t        obs;
  sb_t         sb[$];
  sb_t         cur;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  punc_ctrl_fsm #(
    .HALT_TRAPVECT(8'h25),
    .CC_ON_LEA    (1'b0)
  ) dut (
    .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p),
    .pc_clr(obs.pc_clr), .pc_inc(obs.pc_inc), .pc_ld(obs.pc_ld),
    .pc_data_sel(obs.pc_data_sel), .pc_add_sel(obs.pc_add_sel), .ir_ld(obs.ir_ld),
    .mem_addr_sel(obs.mem_addr_sel), .mem_w_en(obs.mem_w_en), .ind_ld(obs.ind_ld),
    .rf_r_addr_0(obs.rf_r_addr_0), .rf_r_addr_1(obs.rf_r_addr_1), .rf_w_addr(obs.rf_w_addr),
    .rf_w_en(obs.rf_w_en), .rf_w_sel(obs.rf_w_sel), .a_sel(obs.a_sel), .b_sel(obs.b_sel),
    .sext_data(obs.sext_data), .alu_sel(obs.alu_sel), .nzp_sel(obs.nzp_sel),
    .nzp_ld(obs.nzp_ld), .halted(obs.halted)
  );

  function automatic obs_t o_idle();
    obs_t e;
    e = '0;
    return e;
  endfunction

  task automatic push(input string nm, input logic r, input logic [15:0] i,
                      input logic [2:0] f, input obs_t e);
    sb_t s;
    s.name = nm; s.rst = r; s.ir = i; s.nzp = f; s.exp = e;
    sb.push_back(s);
  endtask

  // FETCH then DECODE of one instruction.
  task automatic push_fd(input string nm, input logic [15:0] i, input logic [2:0] f);
    obs_t e;
    e = '0; e.ir_ld = 1'b1;
    push({nm, "_fetch"}, 1'b1, i, f, e);
    e = '0; e.pc_inc = 1'b1;
    push({nm, "_decode"}, 1'b1, i, f, e);
  endtask

  task automatic drive(input sb_t s);
    rst = s.rst; ir = s.ir; {n, z, p} = s.nzp;
  endtask

  task automatic test_reset();
    obs_t e;
    push("rst_low_0", 1'b0, 16'h12BD, 3'b000, o_idle());
    push("rst_low_1", 1'b0, 16'h12BD, 3'b000, o_idle());
    e = '0; e.pc_clr = 1'b1;
    push("init", 1'b1, 16'h0000, 3'b000, e);
    while (sb.size() > 0) begin
      cur = sb.pop_front(); drive(cur);
      @(negedge clk); checks++;
      if (obs !== cur.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", cur.name, obs, cur.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu();
    obs_t e;
    push_fd("add_imm", 16'h12BD, 3'b000);
    e = '0; e.a_sel = 1; e.b_sel = 1; e.alu_sel = 2'd0; e.rf_r_addr_0 = 3'd2;
    e.sext_data = 16'hFFFD; e.rf_w_addr = 3'd1; e.rf_w_sel = 2'd2; e.rf_w_en = 1; e.nzp_ld = 1;
    push("add_imm_exec", 1'b1, 16'h12BD, 3'b000, e);
    push_fd("and_reg", 16'h5705, 3'b010);
    e = '0; e.a_sel = 1; e.b_sel = 0; e.alu_sel = 2'd1; e.rf_r_addr_0 = 3'd4; e.rf_r_addr_1 = 3'd5;
    e.rf_w_addr = 3'd3; e.rf_w_sel = 2'd2; e.rf_w_en = 1; e.nzp_ld = 1;
    push("and_reg_exec", 1'b1, 16'h5705, 3'b010, e);
    push_fd("not", 16'h9C7F, 3'b001);
    e = '0; e.a_sel = 1; e.alu_sel = 2'd3; e.rf_r_addr_0 = 3'd1;
    e.rf_w_addr = 3'd6; e.rf_w_sel = 2'd2; e.rf_w_en = 1; e.nzp_ld = 1;
    push("not_exec", 1'b1, 16'h9C7F, 3'b001, e);
    while (sb.size() > 0) begin
      cur = sb.pop_front(); drive(cur);
      @(negedge clk); checks++;
      if (obs !== cur.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", cur.name, obs, cur.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    obs_t e;
    push_fd("brz_taken", 16'h0405, 3'b010);
    e = '0; e.pc_ld = 1; e.pc_data_sel = 0; e.pc_add_sel = 1;
    push("brz_taken_exec", 1'b1, 16'h0405, 3'b010, e);
    push_fd("brz_not_taken", 16'h0405, 3'b101);
    push("brz_not_taken_exec", 1'b1, 16'h0405, 3'b101, o_idle());
    push_fd("br_nzp000", 16'h0005, 3'b111);
    push("br_nzp000_exec", 1'b1, 16'h0005, 3'b111, o_idle());
    while (sb.size() > 0) begin
      cur = sb.pop_front(); drive(cur);
      @(negedge clk); checks++;
      if (obs !== cur.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", cur.name, obs, cur.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump();
    obs_t e;
    push_fd("jsrr_r7", 16'h41C0, 3'b000);
    e = '0; e.rf_w_en = 1; e.rf_w_addr = 3'd7; e.rf_w_sel = 2'd0; e.pc_ld = 1; e.pc_data_sel = 1;
    e.a_sel = 1; e.alu_sel = 2'd2; e.rf_r_addr_0 = 3'd7;
    push("jsrr_r7_exec", 1'b1, 16'h41C0, 3'b000, e);
    push_fd("jsr", 16'h4810, 3'b000);
    e = '0; e.rf_w_en = 1; e.rf_w_addr = 3'd7; e.rf_w_sel = 2'd0; e.pc_ld = 1;
    e.pc_data_sel = 0; e.pc_add_sel = 0;
    push("jsr_exec", 1'b1, 16'h4810, 3'b000, e);
    push_fd("jmp_r2", 16'hC080, 3'b100);
    e = '0; e.a_sel = 1; e.alu_sel = 2'd2; e.rf_r_addr_0 = 3'd2; e.pc_ld = 1; e.pc_data_sel = 1;
    push("jmp_r2_exec", 1'b1, 16'hC080, 3'b100, e);
    while (sb.size() > 0) begin
      cur = sb.pop_front(); drive(cur);
      @(negedge clk); checks++;
      if (obs !== cur.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", cur.name, obs, cur.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_store();
    obs_t e;
    push_fd("ld", 16'h25FF, 3'b000);
    e = '0; e.a_sel = 0; e.b_sel = 1; e.alu_sel = 2'd0; e.sext_data = 16'hFFFF; e.mem_addr_sel = 2'd1;
    e.rf_w_addr = 3'd2; e.rf_w_sel = 2'd1; e.rf_w_en = 1; e.nzp_sel = 1; e.nzp_ld = 1;
    push("ld_exec", 1'b1, 16'h25FF, 3'b000, e);
    push_fd("str", 16'h787E, 3'b000);
    e = '0; e.a_sel = 1; e.b_sel = 1; e.alu_sel = 2'd0; e.sext_data = 16'hFFFE; e.mem_addr_sel = 2'd1;
    e.rf_r_addr_0 = 3'd1; e.rf_r_addr_1 = 3'd4; e.mem_w_en = 1;
    push("str_exec", 1'b1, 16'h787E, 3'b000, e);
    push_fd("lea", 16'hEA03, 3'b000);
    e = '0; e.b_sel = 1; e.alu_sel = 2'd0; e.sext_data = 16'h0003;
    e.rf_w_addr = 3'd5; e.rf_w_sel = 2'd2; e.rf_w_en = 1; e.nzp_ld = 0;
    push("lea_exec", 1'b1, 16'hEA03, 3'b000, e);
    while (sb.size() > 0) begin
      cur = sb.pop_front(); drive(cur);
      @(negedge clk); checks++;
      if (obs !== cur.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", cur.name, obs, cur.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_indirect();
    obs_t e;
    push_fd("ldi", 16'hA602, 3'b000);
    e = '0; e.b_sel = 1; e.alu_sel = 2'd0; e.sext_data = 16'h0002; e.mem_addr_sel = 2'd1; e.ind_ld = 1;
    push("ldi_exec", 1'b1, 16'hA602, 3'b000, e);
    e = '0; e.mem_addr_sel = 2'd2; e.rf_w_addr = 3'd3; e.rf_w_sel = 2'd1; e.rf_w_en = 1;
    e.nzp_sel = 1; e.nzp_ld = 1;
    push("ldi_exec2", 1'b1, 16'hA602, 3'b000, e);
    push_fd("sti", 16'hB3FC, 3'b000);
    e = '0; e.b_sel = 1; e.alu_sel = 2'd0; e.sext_data = 16'hFFFC; e.mem_addr_sel = 2'd1; e.ind_ld = 1;
    push("sti_exec", 1'b1, 16'hB3FC, 3'b000, e);
    e = '0; e.mem_addr_sel = 2'd2; e.rf_r_addr_1 = 3'd1; e.mem_w_en = 1;
    push("sti_exec2", 1'b1, 16'hB3FC, 3'b000, e);
    while (sb.size() > 0) begin
      cur = sb.pop_front(); drive(cur);
      @(negedge clk); checks++;
      if (obs !== cur.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", cur.name, obs, cur.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_nop();
    push_fd("trap_x20", 16'hF020, 3'b000);
    push("trap_x20_exec", 1'b1, 16'hF020, 3'b000, o_idle());
    push_fd("rti", 16'h8000, 3'b000);
    push("rti_exec", 1'b1, 16'h8000, 3'b000, o_idle());
    while (sb.size() > 0) begin
      cur = sb.pop_front(); drive(cur);
      @(negedge clk); checks++;
      if (obs !== cur.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", cur.name, obs, cur.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_instr();
    obs_t e;
    push_fd("ldi_rst", 16'hA602, 3'b000);
    e = '0; e.b_sel = 1; e.alu_sel = 2'd0; e.sext_data = 16'h0002; e.mem_addr_sel = 2'd1; e.ind_ld = 1;
    push("ldi_rst_exec", 1'b1, 16'hA602, 3'b000, e);
    push("ldi_rst_exec2_low", 1'b0, 16'hA602, 3'b000, o_idle());
    e = '0; e.pc_clr = 1'b1;
    push("ldi_rst_reinit", 1'b1, 16'hA602, 3'b000, e);
    while (sb.size() > 0) begin
      cur = sb.pop_front(); drive(cur);
      @(negedge clk); checks++;
      if (obs !== cur.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", cur.name, obs, cur.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    obs_t e;
    push_fd("trap_x25", 16'hF025, 3'b000);
    e = '0; e.halted = 1'b1;
    for (int i = 0; i < 10; i++)
      push($sformatf("halted_%0d", i), 1'b1, (i % 2 == 0) ? 16'h12BD : 16'hB3FC, 3'b010, e);
    push("halt_rst_low", 1'b0, 16'h0000, 3'b000, o_idle());
    e = '0; e.pc_clr = 1'b1;
    push("halt_reinit", 1'b1, 16'h0000, 3'b000, e);
    while (sb.size() > 0) begin
      cur = sb.pop_front(); drive(cur);
      @(negedge clk); checks++;
      if (obs !== cur.exp) begin
        errors++; $display("FAIL %s: got %h expected %h", cur.name, obs, cur.exp);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_alu();
    test_branch();
    test_jump();
    test_load_store();
    test_indirect();
    test_nop();
    test_reset_mid_instr();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
